// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and RAM port bundle for the load/store unit.
// Ports (slave = load_store_unit, master = CPU side plus RAM):
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : CPU request handshake
//   rsp_valid/rsp_rdata/rsp_error                                : one-cycle completion
//   mem_addr/mem_wr_ena/mem_wr_data/mem_rd_data                  : synchronous-read RAM port
interface load_store_unit_if #(
    parameter int W = 32,
    parameter int L = 128
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [W-1:0]         rsp_rdata;
    logic                 rsp_error;
    logic [$clog2(L)-1:0] mem_addr;
    logic                 mem_wr_ena;
    logic [W-1:0]         mem_wr_data;
    logic [W-1:0]         mem_rd_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wr_ena, mem_wr_data
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wr_ena, mem_wr_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store controller for a word-wide synchronous-read RAM without byte enables.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : load_store_unit_if.slave carrying the request/response handshake and the RAM port
// Loads are lane-extracted and sign/zero extended; byte and halfword stores use read-modify-write.
module load_store_unit #(
    parameter int W = 32,
    parameter int L = 128
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam int AW = $clog2(L);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, RESP} state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]  wr_data_q, wr_data_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          error_q, error_d;

    logic          accept, legal, misaligned, err;
    logic [4:0]    sh;
    logic [15:0]   half;
    logic [7:0]    byte_v;
    logic [W-1:0]  mask, load_val, merged;

    always_comb begin
        accept     = bus.req_valid && bus.req_ready;
        legal      = bus.req_write ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                   : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
                  || (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        // Any set bit above the word index means the address is beyond the RAM.
        err        = !legal || misaligned || bus.req_addr[31:AW+2] != '0;
        sh         = {off_q, 3'b000};
        half       = off_q[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
        byte_v     = off_q[0] ? half[15:8] : half[7:0];
        // funct3[2] distinguishes the unsigned load variants.
        load_val   = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & byte_v[7]}}, byte_v}
                   : funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & half[15]}}, half}
                   : bus.mem_rd_data;
        mask       = funct3_q[0] ? 32'h0000_ffff : 32'h0000_00ff;
        merged     = (bus.mem_rd_data & ~(mask << sh)) | (({16'h0, wdata_q} & mask) << sh);
        state_d    = state_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        wr_data_d  = wr_data_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        unique case (state_q)
            IDLE: if (accept) begin
                write_d    = bus.req_write;
                funct3_d   = bus.req_funct3;
                off_d      = bus.req_addr[1:0];
                wdata_d    = bus.req_wdata[15:0];
                mem_addr_d = bus.req_addr[AW+1:2];
                wr_data_d  = bus.req_wdata;
                rdata_d    = '0;
                error_d    = err;
                state_d    = err ? RESP : (bus.req_write && bus.req_funct3 == 3'b010) ? WRITE : ADDR;
            end
            ADDR:  state_d = DATA;
            DATA: begin
                if (write_q) wr_data_d = merged;
                else rdata_d = load_val;
                state_d = write_q ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            wr_data_q  <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            wr_data_q  <= wr_data_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    assign bus.req_ready   = state_q == IDLE && !rst;
    assign bus.rsp_valid   = state_q == RESP;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_error   = error_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_ena  = state_q == WRITE;
    assign bus.mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector bench for load_store_unit with a synchronous-read RAM model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_ram = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] ram [128];

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 128; i++) ram[i] <= 32'h0;
            ram[3] <= 32'h8765_43F1;
        end else if (bus.mem_wr_ena) begin
            ram[bus.mem_addr] <= bus.mem_wr_data;
        end
        bus.mem_rd_data <= ram[bus.mem_addr];
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        do_wr;
        logic [6:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int cyc;
        int lat;
        int wr_n;
        int wr_lat;
        logic [6:0]  wa;
        logic [31:0] wd;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        cyc = 0;
        while (!bus.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " ready"}, {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        wr_n = 0;
        wr_lat = 0;
        wa = '0;
        wd = '0;
        while (!bus.rsp_valid && lat < 12) begin
            if (bus.mem_wr_ena) begin
                wr_n++;
                wr_lat = lat;
                wa = bus.mem_addr;
                wd = bus.mem_wr_data;
            end
            @(negedge clk);
            lat++;
        end
        if (bus.mem_wr_ena) wr_n++;
        chk({v.name, " latency"}, lat, v.lat);
        chk({v.name, " rdata"}, bus.rsp_rdata, v.rdata);
        chk({v.name, " error"}, {31'h0, bus.rsp_error}, {31'h0, v.err});
        chk({v.name, " write count"}, wr_n, v.do_wr ? 1 : 0);
        if (v.do_wr) begin
            chk({v.name, " write addr"}, {25'h0, wa}, {25'h0, v.wa});
            chk({v.name, " write data"}, wd, v.wd);
            chk({v.name, " write cycle"}, wr_lat, v.lat - 1);
        end
        @(negedge clk);
        chk({v.name, " rsp pulse"}, {31'h0, bus.rsp_valid}, 32'h0);
        chk({v.name, " idle ready"}, {31'h0, bus.req_ready}, 32'h1);
    endtask

    initial begin
        logic [11:0] acc;
        logic [11:0] rsp;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        vecs[0]  = '{"LB 0C",   1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFF_FFF1, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[1]  = '{"LBU 0D",  1'b0, 3'b100, 32'h0D, 32'h0, 32'h0000_0043, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[2]  = '{"LHU 0E",  1'b0, 3'b101, 32'h0E, 32'h0, 32'h0000_8765, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[3]  = '{"LH 0E",   1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF_8765, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[4]  = '{"SH 0E",   1'b1, 3'b001, 32'h0E, 32'h1234_BEEF, 32'h0, 1'b0, 4, 1'b1, 7'd3, 32'hBEEF_43F1};
        vecs[5]  = '{"LW 0C",   1'b0, 3'b010, 32'h0C, 32'h0, 32'hBEEF_43F1, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[6]  = '{"SW 10",   1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1, 7'd4, 32'hDEAD_BEEF};
        vecs[7]  = '{"LW 10",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[8]  = '{"SB 0D",   1'b1, 3'b000, 32'h0D, 32'h7777_77AA, 32'h0, 1'b0, 4, 1'b1, 7'd3, 32'hBEEF_AAF1};
        vecs[9]  = '{"LB 0D",   1'b0, 3'b000, 32'h0D, 32'h0, 32'hFFFF_FFAA, 1'b0, 3, 1'b0, 7'd0, 32'h0};
        vecs[10] = '{"LW 0E",   1'b0, 3'b010, 32'h0E, 32'h0, 32'h0, 1'b1, 1, 1'b0, 7'd0, 32'h0};
        vecs[11] = '{"SH 0D",   1'b1, 3'b001, 32'h0D, 32'h5555_5555, 32'h0, 1'b1, 1, 1'b0, 7'd0, 32'h0};
        vecs[12] = '{"LW 200",  1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1, 1, 1'b0, 7'd0, 32'h0};
        vecs[13] = '{"LD f3 3", 1'b0, 3'b011, 32'h0C, 32'h0, 32'h0, 1'b1, 1, 1'b0, 7'd0, 32'h0};
        vecs[14] = '{"ST f3 4", 1'b1, 3'b100, 32'h0C, 32'h1111_1111, 32'h0, 1'b1, 1, 1'b0, 7'd0, 32'h0};
        vecs[15] = '{"LW high", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b1, 1, 1'b0, 7'd0, 32'h0};
        vecs[16] = '{"LHU 0C",  1'b0, 3'b101, 32'h0C, 32'h0, 32'h0000_AAF1, 1'b0, 3, 1'b0, 7'd0, 32'h0};

        #1;
        chk("reset ready", {31'h0, bus.req_ready}, 32'h0);
        chk("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("reset rdata", bus.rsp_rdata, 32'h0);
        chk("reset error", {31'h0, bus.rsp_error}, 32'h0);
        chk("reset mem_addr", {25'h0, bus.mem_addr}, 32'h0);
        chk("reset wr_ena", {31'h0, bus.mem_wr_ena}, 32'h0);
        chk("reset wr_data", bus.mem_wr_data, 32'h0);
        repeat (3) @(negedge clk);
        init_ram = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready after reset", {31'h0, bus.req_ready}, 32'h1);

        for (int i = 0; i < 17; i++) do_txn(vecs[i]);

        // Reset during ADDR of SB 0C must abandon the store.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0C;
        bus.req_wdata  = 32'h0000_0055;
        chk("rst-sb ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst-sb ready low", {31'h0, bus.req_ready}, 32'h0);
        chk("rst-sb wr_ena", {31'h0, bus.mem_wr_ena}, 32'h0);
        chk("rst-sb mem_addr", {25'h0, bus.mem_addr}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst-sb ready rise", {31'h0, bus.req_ready}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst-sb quiet", {30'h0, bus.rsp_valid, bus.mem_wr_ena}, 32'h0);
        end
        chk("rst-sb ram word 3", ram[3], 32'hBEEF_AAF1);
        do_txn('{"LW 0C post-rst", 1'b0, 3'b010, 32'h0C, 32'h0, 32'hBEEF_AAF1, 1'b0, 3, 1'b0, 7'd0, 32'h0});

        // Held req_valid: one acceptance per IDLE visit.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        for (int k = 0; k < 12; k++) begin
            acc[k] = bus.req_valid && bus.req_ready;
            rsp[k] = bus.rsp_valid;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("b2b accepts", {20'h0, acc}, 32'h0000_0111);
        chk("b2b responses", {20'h0, rsp}, 32'h0000_0888);
        chk("b2b rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Requester-side controller for one port of the team's synchronous-read, word-wide block RAM. It accepts RISC-V load/store requests from the CPU datapath over a valid/ready handshake and drives the RAM port's address, write-enable and write-data. It performs byte-lane extraction and sign/zero extension on loads, and read-modify-write for byte and halfword stores, because the RAM has no byte enables. It sits between the CPU's memory stage and the data RAM.

## Interface
- `W`, 32: RAM word width; fixed at 32 for RV32.
- `L`, 128: RAM depth in words; the word index is `addr[$clog2(L)+1:2]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE and forced 0 while `rst` is high.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_error` out 1: valid with `rsp_valid`. Set for misaligned access, illegal funct3, or word index ≥ L.
- `mem_addr` out $clog2(L): RAM word address.
- `mem_wr_ena` out 1: RAM write enable; decoded from state.
- `mem_wr_data` out W: RAM write word.
- `mem_rd_data` in W: RAM read data; valid the cycle after `mem_addr` is sampled.

## Operation
- **States:** IDLE, ADDR, DATA, WRITE, RESP.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`, latch `write`, `funct3`, `addr`, `wdata`, and load `mem_addr` with the word index. Then:
  - Error check fails → RESP with the error flag set.
  - SW → WRITE, with the merged word = `req_wdata`.
  - Otherwise → ADDR.
- **Error conditions:** any of the following:
  - LH, LHU or SH with `addr[0]`=1.
  - LW or SW with `addr[1:0]`≠0.
  - funct3 not in the legal list for the access type.
  - `addr[31:2]` ≥ L (upper address bits must be zero).
- **ADDR:** RAM samples `mem_addr` at the end of this cycle → DATA.
- **DATA:** `mem_rd_data` is valid.
  - Loads: select byte lane `addr[1:0]` or halfword `addr[1]`, sign-extend (LB/LH) or zero-extend (LBU/LHU), register into `rsp_rdata` → RESP.
  - SB/SH: build the merged word by replacing the addressed byte/halfword of `mem_rd_data` with the low bits of the latched `wdata`; register it → WRITE.
- **WRITE:** `mem_wr_ena`=1 and `mem_wr_data`=merged word for exactly this cycle → RESP.
- **RESP:** `rsp_valid`=1 for one cycle → IDLE.
- `mem_wr_ena` is 0 in every state except WRITE. `mem_addr` holds the latched index outside IDLE-acceptance.
- `rsp_rdata` and `rsp_error` hold their values until the next request is accepted.

## Timing
- Let cycle N be the handshake cycle (`req_valid && req_ready`).
- Load: ADDR in N+1, DATA in N+2, `rsp_valid` in N+3.
- SB/SH: ADDR N+1, DATA N+2, write in N+3, `rsp_valid` in N+4.
- SW: write in N+1, `rsp_valid` in N+2.
- Error: `rsp_valid` with `rsp_error`=1 in N+1; no RAM write.
- Next acceptance is no earlier than the cycle after RESP. No pipelining or overlap.
- **Reset values:** state IDLE; `req_ready` 0 while `rst` is high; `rsp_valid` 0, `rsp_rdata` 0, `rsp_error` 0, `mem_addr` 0, `mem_wr_ena` 0, `mem_wr_data` 0.
- **Reset mid-operation:** the transaction is abandoned with no response. `mem_wr_ena` drops asynchronously with `rst`. A store interrupted before WRITE leaves RAM unchanged.
- **Input stability:** `req_*` inputs are ignored outside IDLE. Holding `req_valid` high produces one acceptance per IDLE visit.

## Test plan
- RAM word 3 = 0x876543F1. LB 0x0C → `rsp_rdata` 0xFFFFFFF1 at N+3. LBU 0x0D → 0x00000043. LHU 0x0E → 0x00008765. LH 0x0E → 0xFFFF8765.
- SH 0x0E, wdata 0x1234BEEF → single `mem_wr_ena` pulse at N+3 to address 3 with data 0xBEEF43F1, `rsp_valid` at N+4. A following LW 0x0C returns 0xBEEF43F1.
- SW 0x10, wdata 0xDEADBEEF → write to address 4 at N+1, `rsp_valid` at N+2, `rsp_error` 0. A following LW 0x10 returns 0xDEADBEEF.
- Errors, each giving `rsp_error`=1 at N+1 with `rsp_rdata` 0 and no `mem_wr_ena`: LW 0x0E; SH 0x0D; LW 0x200 (index 128 = L); funct3 011 on a load.
- Assert `rst` during the ADDR state of SB 0x0C → no write, word 3 unchanged, no `rsp_valid`. `req_ready` rises on the first cycle after `rst` deasserts.
- `req_valid` held high with three back-to-back LW requests → accepted at cycles 0, 4 and 8; `rsp_valid` at cycles 3, 7 and 11.
